// File: rtl/seg7_scan_ctrl_if.sv
// Display-load handshake and multiplexed 7-segment drive lines for seg7_scan_ctrl.
interface seg7_scan_ctrl_if;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        lz_en;
    logic [6:0]  seg7out;
    logic        seg7dp;
    logic [3:0]  seg7com;
    logic        frame_done;

    modport master (
        output load_valid, digits, dp, lz_en,
        input  load_ready, seg7out, seg7dp, seg7com, frame_done
    );

    modport slave (
        input  load_valid, digits, dp, lz_en,
        output load_ready, seg7out, seg7dp, seg7com, frame_done
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with blanking and a one-entry load buffer.
// state  | meaning
// BLANK  | all digit enables off for BLANK_CYC cycles at the start of a slot
// DRIVE  | digit idx enabled for SCAN_DIV-BLANK_CYC cycles
module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 12500,
    parameter int BLANK_CYC = 500
) (
    input  logic            clk,
    input  logic            rst,
    seg7_scan_ctrl_if.slave bus
);
    localparam int DRIVE_CYC = SCAN_DIV - BLANK_CYC;
    localparam int CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   act_digits, pend_digits;
    logic [3:0]    act_dp, pend_dp;
    logic          pend_full;
    logic [6:0]    seg_r, seg_n;
    logic          dp_r, dp_n;
    logic [3:0]    com_r, com_n;
    logic          fd_r, fd_n;
    logic          last_blank, last_drive, boundary, accept, suppress;
    logic [3:0]    sel;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        last_blank = (state == ST_BLANK) && (cnt == CW'(BLANK_CYC - 1));
        last_drive = (state == ST_DRIVE) && (cnt == CW'(DRIVE_CYC - 1));
        boundary   = last_drive && (idx == 2'd3);
        accept     = bus.load_valid && !pend_full;

        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + CW'(1);
        if (last_blank) begin
            state_n = ST_DRIVE;
            cnt_n   = '0;
        end else if (last_drive) begin
            state_n = ST_BLANK;
            idx_n   = idx + 2'd1;
            cnt_n   = '0;
        end

        // Output regs carry the next state's view; active data only changes on entry to BLANK.
        sel = act_digits[{idx_n, 2'b00} +: 4];
        case (idx_n)
            2'd3:    suppress = bus.lz_en && (act_digits[15:12] == 4'd0);
            2'd2:    suppress = bus.lz_en && (act_digits[15:8] == 8'd0);
            2'd1:    suppress = bus.lz_en && (act_digits[15:4] == 12'd0);
            default: suppress = 1'b0;
        endcase

        seg_n = 7'h7F;
        dp_n  = 1'b1;
        com_n = 4'hF;
        if (state_n == ST_DRIVE) begin
            seg_n = suppress ? 7'h7F : decode(sel);
            dp_n  = ~act_dp[idx_n];
            com_n = ~(4'b0001 << idx_n);
        end
        fd_n = (state_n == ST_DRIVE) && (idx_n == 2'd3) && (cnt_n == CW'(DRIVE_CYC - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_BLANK;
            idx         <= 2'd0;
            cnt         <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_full   <= 1'b0;
            seg_r       <= 7'h7F;
            dp_r        <= 1'b1;
            com_r       <= 4'hF;
            fd_r        <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            seg_r <= seg_n;
            dp_r  <= dp_n;
            com_r <= com_n;
            fd_r  <= fd_n;
            if (boundary && pend_full) begin
                act_digits <= pend_digits;
                act_dp     <= pend_dp;
                pend_full  <= 1'b0;
            end
            if (accept) begin
                pend_digits <= bus.digits;
                pend_dp     <= bus.dp;
                pend_full   <= 1'b1;
            end
        end
    end

    assign bus.load_ready = !pend_full;
    assign bus.seg7out    = seg_r;
    assign bus.seg7dp     = dp_r;
    assign bus.seg7com    = com_r;
    assign bus.frame_done = fd_r;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: frame-position model checked every cycle, directed scenarios, random loads.
module tb_seg7_scan_ctrl;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FR = 4 * SD;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
    };

    logic clk;
    logic rst;
    seg7_scan_ctrl_if bus();

    seg7_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          m_t   = 0;
    logic [15:0] m_act = '0;
    logic [15:0] m_pend = '0;
    logic [3:0]  m_act_dp = '0;
    logic [3:0]  m_pend_dp = '0;
    bit          m_pfull = 1'b0;
    bit          m_lz = 1'b0;
    bit          cur_lz = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s at t=%0d: actual %0h required %0h", name, m_t, act, req);
        end
    endtask

    task automatic compare_model();
        int          pos, slot;
        bit          drv, supp;
        logic [15:0] hi;
        logic [3:0]  dig;
        logic [6:0]  e_seg;
        logic [3:0]  e_com;
        logic        e_dp;
        pos   = m_t % SD;
        slot  = (m_t / SD) % 4;
        drv   = (pos >= BC);
        hi    = m_act >> (4 * slot);
        dig   = hi[3:0];
        supp  = m_lz && (slot > 0) && (hi == 16'd0);
        e_seg = drv ? (supp ? 7'h7F : SEG_TAB[dig]) : 7'h7F;
        e_com = drv ? (4'hF & ~(4'b0001 << slot)) : 4'hF;
        e_dp  = drv ? ~m_act_dp[slot] : 1'b1;
        chk("seg7out", 32'(bus.seg7out), 32'(e_seg));
        chk("seg7com", 32'(bus.seg7com), 32'(e_com));
        chk("seg7dp", 32'(bus.seg7dp), 32'(e_dp));
        chk("frame_done", 32'(bus.frame_done), 32'((m_t % FR) == FR - 1));
        chk("load_ready", 32'(bus.load_ready), 32'(!m_pfull));
    endtask

    task automatic step(input bit r, input bit v, input logic [15:0] d, input logic [3:0] p);
        rst            = r;
        bus.load_valid = v;
        bus.digits     = d;
        bus.dp         = p;
        bus.lz_en      = cur_lz;
        @(posedge clk);
        if (r) begin
            m_t      = 0;
            m_act    = '0;
            m_act_dp = '0;
            m_pfull  = 1'b0;
        end else begin
            if (((m_t % FR) == FR - 1) && m_pfull) begin
                m_act    = m_pend;
                m_act_dp = m_pend_dp;
                m_pfull  = 1'b0;
            end else if (v && !m_pfull) begin
                m_pend    = d;
                m_pend_dp = p;
                m_pfull   = 1'b1;
            end
            m_t++;
        end
        m_lz = cur_lz;
        @(negedge clk);
        compare_model();
    endtask

    task automatic go_to(input int tt);
        int guard = 0;
        while (m_t != tt && guard < 2000) begin
            step(1'b0, 1'b0, 16'h0, 4'h0);
            guard++;
        end
        if (m_t != tt) chk("go_to_bound", 32'(m_t), 32'(tt));
    endtask

    initial begin
        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.digits     = '0;
        bus.dp         = '0;
        bus.lz_en      = 1'b0;

        repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0);
        chk("rst_ready", 32'(bus.load_ready), 32'd1);
        chk("rst_com", 32'(bus.seg7com), 32'hF);
        chk("rst_seg", 32'(bus.seg7out), 32'h7F);
        chk("rst_dp", 32'(bus.seg7dp), 32'd1);
        chk("rst_fd", 32'(bus.frame_done), 32'd0);

        go_to(1);  chk("t1_com", 32'(bus.seg7com), 32'hF);
        go_to(2);  chk("t2_com", 32'(bus.seg7com), 32'hE);
                   chk("t2_seg", 32'(bus.seg7out), 32'b1000000);
        go_to(8);  chk("t8_com", 32'(bus.seg7com), 32'hF);
        go_to(10); chk("t10_com", 32'(bus.seg7com), 32'hD);
        go_to(30); chk("t30_fd", 32'(bus.frame_done), 32'd0);
        go_to(31); chk("t31_fd", 32'(bus.frame_done), 32'd1);

        go_to(40);
        step(1'b0, 1'b1, 16'h1234, 4'b0100);
        chk("load_rdy_low", 32'(bus.load_ready), 32'd0);
        step(1'b0, 1'b1, 16'h9999, 4'hF);
        go_to(63); chk("t63_rdy", 32'(bus.load_ready), 32'd0);
        go_to(64); chk("t64_rdy", 32'(bus.load_ready), 32'd1);
        go_to(66); chk("d0_is_4", 32'(bus.seg7out), 32'b0011001);
                   chk("d0_dp_off", 32'(bus.seg7dp), 32'd1);
        go_to(74); chk("d1_is_3", 32'(bus.seg7out), 32'b0110000);
        go_to(82); chk("d2_is_2", 32'(bus.seg7out), 32'b0100100);
                   chk("d2_dp_on", 32'(bus.seg7dp), 32'd0);
                   chk("d2_com", 32'(bus.seg7com), 32'hB);
        go_to(90); chk("d3_is_1", 32'(bus.seg7out), 32'b1111001);

        go_to(100);
        step(1'b0, 1'b1, 16'h1111, 4'h0);
        step(1'b0, 1'b1, 16'h2222, 4'h0);
        go_to(106); chk("old_word_kept", 32'(bus.seg7out), 32'b0110000);
        go_to(127); chk("t127_rdy", 32'(bus.load_ready), 32'd0);
        go_to(128); chk("t128_rdy", 32'(bus.load_ready), 32'd1);
        step(1'b0, 1'b1, 16'h2222, 4'h0);
        go_to(130); chk("show_1111", 32'(bus.seg7out), 32'b1111001);
        go_to(162); chk("show_2222", 32'(bus.seg7out), 32'b0100100);

        go_to(191); chk("bnd_rdy", 32'(bus.load_ready), 32'd1);
        step(1'b0, 1'b1, 16'h0007, 4'h0);
        chk("bnd_accepted", 32'(bus.load_ready), 32'd0);
        go_to(194); chk("bnd_not_yet", 32'(bus.seg7out), 32'b0100100);
        go_to(226); chk("show_7", 32'(bus.seg7out), 32'b1111000);
        go_to(250); chk("lz_off_d3", 32'(bus.seg7out), 32'b1000000);
        cur_lz = 1'b1;
        go_to(258); chk("lz_on_d0", 32'(bus.seg7out), 32'b1111000);
        go_to(266); chk("lz_on_d1", 32'(bus.seg7out), 32'h7F);
        go_to(282); chk("lz_on_d3", 32'(bus.seg7out), 32'h7F);
                    chk("lz_on_com", 32'(bus.seg7com), 32'h7);

        go_to(290);
        step(1'b0, 1'b1, 16'h5678, 4'hF);
        go_to(306); chk("pre_rst_com", 32'(bus.seg7com), 32'hB);
        step(1'b1, 1'b0, 16'h0, 4'h0);
        chk("mid_rst_com", 32'(bus.seg7com), 32'hF);
        chk("mid_rst_seg", 32'(bus.seg7out), 32'h7F);
        chk("mid_rst_dp", 32'(bus.seg7dp), 32'd1);
        chk("mid_rst_rdy", 32'(bus.load_ready), 32'd1);
        go_to(2);  chk("post_rst_d0", 32'(bus.seg7out), 32'b1000000);
                   chk("post_rst_com", 32'(bus.seg7com), 32'hE);
        go_to(10); chk("post_rst_d1", 32'(bus.seg7out), 32'h7F);
        go_to(34); chk("pend_discarded", 32'(bus.seg7out), 32'b1000000);

        for (int i = 0; i < 1500; i++) begin
            bit          r, v;
            logic [15:0] d;
            r = ($urandom_range(0, 399) == 0);
            v = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 99)) : 16'($urandom);
            if ($urandom_range(0, 99) == 0) cur_lz = ~cur_lz;
            step(r, v, d, 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
